counter_cmd_sequencer: RTL and testbench
========================================

Name: counter_cmd_sequencer

Overview:
- Upstream command stage for the N-bit universal counter.
- Accepts counter commands over a valid/ready interface and buffers them in a small FIFO.
- Drives the counter's 2-bit control and parallel_in inputs cycle by cycle, expanding each command into a run of repeated operations.
- Lets software or a controller schedule count, load and hold sequences without per-cycle intervention.

Parameters:
- N, 8, counter data width; width of cmd_data and parallel_in.
- REP_W, 8, width of the repeat field.
- FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- abort  in  1  synchronous flush: drop current command and all queued commands.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_op  in  2  00 hold, 01 up, 10 down, 11 load (counter encoding).
- cmd_data  in  N  load value; used only for op 11.
- cmd_rep  in  REP_W  repeat count; op executes cmd_rep+1 cycles; ignored for load.
- control  out  2  registered; to counter control.
- parallel_in  out  N  registered; to counter parallel_in.
- busy  out  1  high while a command is executing.
- cmd_done  out  1  high during the final control cycle of each command.
- fifo_level  out  clog2(FIFO_DEPTH)+1  entries currently queued.

Behaviour:
- Reset values: control=00, parallel_in=0, busy=0, cmd_done=0, cmd_ready=1, fifo_level=0; FIFO empty; FSM in IDLE.
- Accept: a command is written into the FIFO on a clk edge where cmd_valid&&cmd_ready. cmd_valid while full is ignored; the source must hold it.
- FSM states:
  - IDLE: control=00, busy=0. On an edge with the FIFO non-empty: pop the head, load the remaining-count register with cmd_rep, go to RUN.
  - RUN: control=op, busy=1, remaining decrements each cycle. For load, control=11 and parallel_in=cmd_data for exactly 1 cycle.
- Last cycle of a command (remaining==0, or load): cmd_done=1.
  - If the FIFO is non-empty on that edge, pop the next command and stay in RUN, with no gap cycle.
  - Otherwise return to IDLE; control=00 from the next cycle.
- Latency: a command accepted at edge k into an empty FIFO with the FSM in IDLE drives control from edge k+1. The first operation is visible at the counter output after edge k+2.
- parallel_in is updated only when a load is issued, and holds its last value otherwise.
- Repeat: a cmd_rep of 2^REP_W-1 executes 2^REP_W cycles. The remaining counter never wraps.
- Simultaneous push and pop: fifo_level is unchanged. A push into an empty FIFO and a pop on the same edge are not allowed; the pop sees the entry one cycle later.
- fifo_level counts queued entries only, not the executing command.
- abort (synchronous, highest priority below reset): on the edge where it is high, the FIFO empties, the FSM goes to IDLE, and control=00. A command presented on the same edge is discarded. cmd_done is not asserted for the aborted command.
- Reset mid-command: all state returns to reset values immediately. No partial command resumes.

Optional Feature:
- Macro: CMD_SEQ_STATS_EN.
- When defined, adds output stat_cmds[15:0]: counts commands that completed (cmd_done cycles). It saturates at 16'hFFFF and clears on reset only; abort does not clear it.
- When undefined, stat_cmds exists but is tied to 0 and no counter logic is built.

Test Plan:
- Reset, then push {op=01, rep=3} -> control=01 for exactly 4 cycles starting 1 cycle after accept; cmd_done on the 4th; control=00 after; busy high for those 4 cycles.
- Push back-to-back {11, data=8'hA5}, {10, rep=1}, {00, rep=0} -> control sequence 11,10,10,00 with no gaps; parallel_in=A5 from the load cycle on; cmd_done in cycles 1, 3 and 4.
- Hold cmd_valid high with 6 commands of {01, rep=9}, FIFO_DEPTH=4 -> cmd_ready drops when fifo_level=4; no command lost; all 6 execute in order (60 up cycles total).
- Assert abort mid-run of {01, rep=20} with 2 queued -> control=00 the next cycle, fifo_level=0, busy=0, no cmd_done; a later push executes normally.
- Deassert rst_n asynchronously mid-command -> outputs return to reset values immediately. With CMD_SEQ_STATS_EN, stat_cmds=0 after reset and increments by 1 per completed command.
- Push {01, rep=255} with REP_W=8 -> control=01 for exactly 256 cycles; cmd_done once.

Source files
------------

// File: rtl/counter_cmd_sequencer_if.sv
// rtl/counter_cmd_sequencer_if.sv - command valid/ready bundle feeding the counter command sequencer
interface counter_cmd_sequencer_if #(
  parameter int N     = 8,
  parameter int REP_W = 8
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [N-1:0]     cmd_data;
  logic [REP_W-1:0] cmd_rep;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    output cmd_rep,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    input  cmd_rep,
    output cmd_ready
  );
endinterface

// File: rtl/counter_cmd_sequencer.sv
// rtl/counter_cmd_sequencer.sv - queues counter commands and expands each into repeated control cycles
// Optional completed-command counter on stat_cmds is built only when CMD_SEQ_STATS_EN is defined.
module counter_cmd_sequencer #(
  parameter int N          = 8,
  parameter int REP_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          abort,
  counter_cmd_sequencer_if.slave        cmd,
  output logic [1:0]                    control,
  output logic [N-1:0]                  parallel_in,
  output logic                          busy,
  output logic                          cmd_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   stat_cmds
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = 2 + N + REP_W;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;

  logic [0:0]       state;
  logic [1:0]       cur_op;
  logic [REP_W-1:0] remaining;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             is_last;
  logic [1:0]       head_op;
  logic [N-1:0]     head_data;
  logic [REP_W-1:0] head_rep;

  assign full  = (level == LVL_W'(FIFO_DEPTH));
  assign empty = (level == '0);

  assign cmd.cmd_ready = !full;
  assign fifo_level    = level;

  // A command offered on an abort edge is discarded along with the queue.
  assign push = cmd.cmd_valid && !full && !abort;

  // Load is always a single cycle; other ops finish when the count reaches zero.
  assign is_last = (cur_op == OP_LOAD) || (remaining == '0);

  // The pop decision uses the registered level, so an entry pushed this edge
  // is never popped on the same edge.
  assign pop = !abort && !empty && ((state == ST_IDLE) || is_last);

  assign {head_op, head_data, head_rep} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd.cmd_op, cmd.cmd_data, cmd.cmd_rep};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cur_op      <= OP_HOLD;
      remaining   <= '0;
      control     <= OP_HOLD;
      parallel_in <= '0;
      busy        <= 1'b0;
      cmd_done    <= 1'b0;
    end else if (abort) begin
      state    <= ST_IDLE;
      control  <= OP_HOLD;
      busy     <= 1'b0;
      cmd_done <= 1'b0;
    end else if (pop) begin
      // Chaining straight from the last cycle of the previous command keeps
      // back-to-back commands gap-free.
      state     <= ST_RUN;
      cur_op    <= head_op;
      remaining <= head_rep;
      control   <= head_op;
      busy      <= 1'b1;
      cmd_done  <= (head_op == OP_LOAD) || (head_rep == '0);
      if (head_op == OP_LOAD) begin
        parallel_in <= head_data;
      end
    end else if (state == ST_RUN) begin
      if (is_last) begin
        state    <= ST_IDLE;
        control  <= OP_HOLD;
        busy     <= 1'b0;
        cmd_done <= 1'b0;
      end else begin
        remaining <= remaining - REP_W'(1);
        cmd_done  <= (remaining == REP_W'(1));
      end
    end
  end

`ifdef CMD_SEQ_STATS_EN
  logic [15:0] stat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else if (cmd_done && (stat_q != 16'hFFFF)) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign stat_cmds = stat_q;
`else
  assign stat_cmds = '0;
`endif

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// tb/tb_counter_cmd_sequencer.sv - randomized self-checking bench for counter_cmd_sequencer against a queue-based model
module tb_counter_cmd_sequencer;

  localparam int N     = 8;
  localparam int REP_W = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [1:0]       op;
    logic [N-1:0]     data;
    logic [REP_W-1:0] rep;
  } cmd_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             abort;
  logic [1:0]       control;
  logic [N-1:0]     parallel_in;
  logic             busy;
  logic             cmd_done;
  logic [2:0]       fifo_level;
  logic [15:0]      stat_cmds;

  counter_cmd_sequencer_if #(.N(N), .REP_W(REP_W)) cmd_if ();

  counter_cmd_sequencer #(.N(N), .REP_W(REP_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .abort       (abort),
    .cmd         (cmd_if.slave),
    .control     (control),
    .parallel_in (parallel_in),
    .busy        (busy),
    .cmd_done    (cmd_done),
    .fifo_level  (fifo_level),
    .stat_cmds   (stat_cmds)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference: accepted commands wait in mq; the executing one has m_left cycles to go.
  cmd_t       mq[$];
  cmd_t       src_q[$];
  bit         m_active;
  int         m_left;
  logic [1:0] m_ctrl;
  logic [7:0] m_pin;
  bit         m_busy;
  bit         m_done;
  int         m_stat;

  int obs_up;
  int obs_done;
  int max_lvl;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_active = 0;
    m_left   = 0;
    m_ctrl   = 2'b00;
    m_pin    = '0;
    m_busy   = 0;
    m_done   = 0;
    m_stat   = 0;
  endtask

  task automatic model_edge(input bit valid, input cmd_t in, input bit ab, output bit acc);
    cmd_t c;
    acc = 0;
    if (m_done && m_stat < 65535) m_stat++;
    if (ab) begin
      mq.delete();
      m_active = 0;
      m_ctrl   = 2'b00;
      m_busy   = 0;
      m_done   = 0;
      return;
    end
    acc = valid && (mq.size() < DEPTH);
    if (!m_active || m_left == 1) begin
      if (mq.size() > 0) begin
        c        = mq.pop_front();
        m_active = 1;
        m_left   = (c.op == 2'b11) ? 1 : int'(c.rep) + 1;
        m_ctrl   = c.op;
        if (c.op == 2'b11) m_pin = c.data;
      end else begin
        m_active = 0;
        m_ctrl   = 2'b00;
      end
    end else begin
      m_left--;
    end
    m_busy = m_active;
    m_done = m_active && (m_left == 1);
    if (acc) mq.push_back(in);
  endtask

  task automatic drive_inputs();
    cmd_if.cmd_valid = (src_q.size() > 0);
    if (src_q.size() > 0) begin
      cmd_if.cmd_op   = src_q[0].op;
      cmd_if.cmd_data = src_q[0].data;
      cmd_if.cmd_rep  = src_q[0].rep;
    end else begin
      cmd_if.cmd_op   = 2'b00;
      cmd_if.cmd_data = '0;
      cmd_if.cmd_rep  = '0;
    end
  endtask

  task automatic compare_all();
    check_val("control", 32'(control), 32'(m_ctrl));
    check_val("parallel_in", 32'(parallel_in), 32'(m_pin));
    check_val("busy", 32'(busy), 32'(m_busy));
    check_val("cmd_done", 32'(cmd_done), 32'(m_done));
    check_val("fifo_level", 32'(fifo_level), mq.size());
    check_val("cmd_ready", 32'(cmd_if.cmd_ready), 32'(mq.size() < DEPTH));
`ifdef CMD_SEQ_STATS_EN
    check_val("stat_cmds", 32'(stat_cmds), m_stat);
`else
    check_val("stat_cmds", 32'(stat_cmds), 0);
`endif
  endtask

  task automatic tick();
    bit   acc;
    cmd_t head;
    head = '{op: 2'b00, data: '0, rep: '0};
    if (src_q.size() > 0) head = src_q[0];
    @(posedge clk);
    acc = 0;
    if (!rst_n) model_reset();
    else model_edge(src_q.size() > 0, head, abort, acc);
    #1;
    compare_all();
    if (control == 2'b01) obs_up++;
    if (cmd_done) obs_done++;
    if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
    if (acc) void'(src_q.pop_front());
    abort = 1'b0;
    drive_inputs();
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [7:0] data, input logic [7:0] rep);
    src_q.push_back('{op: op, data: data, rep: rep});
    drive_inputs();
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((m_active || mq.size() > 0 || src_q.size() > 0) && n < bound) begin
      tick();
      n++;
    end
    check_val("drain_bound", 32'(n < bound), 1);
    tick();
  endtask

  task automatic clear_obs();
    obs_up   = 0;
    obs_done = 0;
    max_lvl  = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    abort = 1'b0;
    model_reset();
    clear_obs();
    drive_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // single up command, rep=3
    clear_obs();
    push_cmd(2'b01, 8'h00, 8'd3);
    drain(50);
    check_val("s1_up_cycles", obs_up, 4);
    check_val("s1_done_count", obs_done, 1);

    // load, down x2, hold x1 back to back
    clear_obs();
    push_cmd(2'b11, 8'hA5, 8'd7);
    push_cmd(2'b10, 8'h00, 8'd1);
    push_cmd(2'b00, 8'h00, 8'd0);
    drain(50);
    check_val("s2_done_count", obs_done, 3);
    check_val("s2_parallel_in", 32'(parallel_in), 32'h0000_00A5);

    // six commands against a four-entry FIFO
    clear_obs();
    for (int i = 0; i < 6; i++) push_cmd(2'b01, 8'h00, 8'd9);
    drain(200);
    check_val("s3_up_cycles", obs_up, 60);
    check_val("s3_done_count", obs_done, 6);
    check_val("s3_max_level", max_lvl, DEPTH);

    // abort mid-run with two queued
    clear_obs();
    for (int i = 0; i < 3; i++) push_cmd(2'b01, 8'h00, 8'd20);
    repeat (8) tick();
    abort = 1'b1;
    tick();
    check_val("s4_busy", 32'(busy), 0);
    check_val("s4_level", 32'(fifo_level), 0);
    check_val("s4_control", 32'(control), 0);
    repeat (3) tick();
    check_val("s4_no_done", obs_done, 0);
    push_cmd(2'b10, 8'h00, 8'd2);
    drain(50);
    check_val("s4_post_done", obs_done, 1);

    // asynchronous reset in the middle of a command
    push_cmd(2'b11, 8'h3C, 8'd0);
    push_cmd(2'b01, 8'h00, 8'd30);
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1;
    src_q.delete();
    model_reset();
    drive_inputs();
    compare_all();
    tick();
    tick();
    rst_n = 1'b1;
    clear_obs();
    push_cmd(2'b01, 8'h00, 8'd1);
    push_cmd(2'b01, 8'h00, 8'd0);
    drain(50);
    check_val("s5_done_count", obs_done, 2);

    // maximum repeat count
    clear_obs();
    push_cmd(2'b01, 8'h00, 8'd255);
    drain(400);
    check_val("s6_up_cycles", obs_up, 256);
    check_val("s6_done_count", obs_done, 1);

    // random traffic with occasional aborts
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(2, 0) == 0 && src_q.size() < 3) begin
        push_cmd(2'($urandom_range(3, 0)), 8'($urandom), 8'($urandom_range(5, 0)));
      end
      if ($urandom_range(59, 0) == 0) abort = 1'b1;
      tick();
    end
    drain(2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
